// File: rtl/fifo_wr_packer_pkg.sv
// Shared definitions for the write-side FIFO producer and the FIFO stages.
package fifo_wr_packer_pkg;

    // Default FIFO word width, shared with the pointer/memory stages.
    localparam int FIFO_DATA_WIDTH = 8;

    // Packer state encoding.
    typedef enum logic {
        IDLE = 1'b0,
        PUSH = 1'b1
    } state_e;

endpackage

// File: rtl/fifo_wr_packer.sv
// Write-domain frame packer: takes one wide word (1..MAX_BYTES bytes) per
// handshake and streams it into the async FIFO one byte per cycle,
// stalling on wfull. The last-byte cycle can accept the next frame, so
// back-to-back frames leave no bubble.
module fifo_wr_packer
    import fifo_wr_packer_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int MAX_BYTES  = 2,
    parameter int LEN_W      = 1,
    parameter int MSB_FIRST  = 0
) (
    input  logic                            w_clk,
    input  logic                            wrst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_WIDTH*MAX_BYTES-1:0] in_data,
    input  logic [LEN_W-1:0]                in_nbytes,
    input  logic                            wfull,
    output logic                            w_inc,
    output logic [DATA_WIDTH-1:0]           w_data,
    output logic                            busy
);

    localparam int FRAME_W = DATA_WIDTH * MAX_BYTES;

    state_e             state_q, state_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic [LEN_W-1:0]   rem_q,   rem_d;
    logic [LEN_W-1:0]   len_clamped;

    // Clamp oversized length requests to a full frame.
    always_comb begin
        if (int'(in_nbytes) >= MAX_BYTES) begin
            len_clamped = LEN_W'(MAX_BYTES - 1);
        end else begin
            len_clamped = in_nbytes;
        end
    end

    // Output byte is taken straight from the output end of the shift register.
    always_comb begin
        if (MSB_FIRST != 0) begin
            w_data = shreg_q[FRAME_W-1 -: DATA_WIDTH];
        end else begin
            w_data = shreg_q[DATA_WIDTH-1:0];
        end
    end

    // Next-state, shift/count update and handshake outputs.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        rem_d    = rem_q;
        in_ready = 1'b0;
        w_inc    = 1'b0;
        busy     = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    shreg_d = in_data;
                    rem_d   = len_clamped;
                    state_d = PUSH;
                end
            end
            PUSH: begin
                busy  = 1'b1;
                w_inc = !wfull;
                if (!wfull) begin
                    // Consume the byte at the output end; zero-fill behind it.
                    if (MSB_FIRST != 0) begin
                        shreg_d = shreg_q << DATA_WIDTH;
                    end else begin
                        shreg_d = shreg_q >> DATA_WIDTH;
                    end
                    if (rem_q != '0) begin
                        rem_d = rem_q - LEN_W'(1);
                    end else begin
                        // Last byte leaving: open the door for the next frame.
                        state_d  = IDLE;
                        in_ready = 1'b1;
                        if (in_valid) begin
                            shreg_d = in_data;
                            rem_d   = len_clamped;
                            state_d = PUSH;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // A reset cycle must never write into the FIFO, whatever the state.
        if (wrst) begin
            w_inc = 1'b0;
        end
    end

    // State, shift register and byte counter.
    always_ff @(posedge w_clk) begin
        if (wrst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            rem_q   <= rem_d;
        end
    end

endmodule
